imem_loader: RTL and testbench

//   Write side of the instruction memory: receives a byte stream (UART-RX style valid/ready)
//   and writes a program into imem, one 32-bit word per write, while holding the CPU
//   (program counter) stalled. Releases the CPU via cpu_hold when the image is fully written.

---
 rtl/mips_pkg.sv | 17 +
 rtl/word_assembler.sv | 32 +++
 rtl/imem_loader.sv | 133 +++++++++++++
 tb/tb_imem_loader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared loader definitions: state encoding and stream framing constants.
package mips_pkg;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERROR
    } loader_state_e;

    localparam int WORD_BYTES = 4;  // bytes per instruction word
    localparam int HDR_BYTES  = 2;  // bytes in the word-count header

endpackage

// File: rtl/word_assembler.sv
// Big-endian word assembler: first byte of a word lands in [31:24].
// word_full flags the transfer that completes the current word.
module word_assembler
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    localparam int IDX_W = $clog2(WORD_BYTES);

    logic [IDX_W-1:0] idx;

    // shift register and byte index; cleared after each write so no stale bytes leak
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            word <= '0;
            idx  <= '0;
        end else if (shift_en) begin
            word <= {word[23:0], byte_in};
            idx  <= idx + 1'b1;
        end
    end

    assign word_full = shift_en && (idx == IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a length-prefixed byte stream, writes one
// word per imem_we pulse and holds the CPU until the image is complete.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import mips_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256,
    parameter int          CNT_W     = 16
) (
    input  logic        clk_fpga,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_e END_ST = CSUM;
`else
    localparam loader_state_e END_ST = DONE;
`endif

    loader_state_e    state, state_nx;
    logic [7:0]       cnt_hi;
    logic [15:0]      hdr_cnt;
    logic [CNT_W-1:0] words_left;
    logic             xfer;
    logic             asm_shift;
    logic             asm_clr;
    logic             word_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    // full header count is valid while the low byte is on the bus in LEN_LO
    assign hdr_cnt   = {cnt_hi, byte_data};
    assign xfer      = byte_valid & byte_ready;
    assign asm_shift = xfer && (state == DATA);
    assign asm_clr   = imem_we;

    // state register
    always_ff @(posedge clk_fpga) begin
        if (reset) state <= LEN_HI;
        else       state <= state_nx;
    end

    // next-state: header parse, word collection, single-cycle write, optional check
    always_comb begin
        state_nx = state;
        case (state)
            LEN_HI: if (xfer) state_nx = LEN_LO;
            LEN_LO: begin
                if (xfer) begin
                    if (hdr_cnt == 16'd0)                state_nx = END_ST;
                    else if (int'(hdr_cnt) > MAX_WORDS)  state_nx = ERROR;
                    else                                 state_nx = DATA;
                end
            end
            DATA:   if (word_full) state_nx = WRITE;
            WRITE:  state_nx = (words_left == CNT_W'(1)) ? END_ST : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM:   if (xfer) state_nx = (byte_data == csum) ? DONE : ERROR;
`endif
            default: state_nx = state;
        endcase
    end

    // handshake and write strobe decoded from state; ready drops during the write cycle
    always_comb begin
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        case (state)
            LEN_HI, LEN_LO, DATA, CSUM: byte_ready = 1'b1;
            WRITE:                      imem_we    = 1'b1;
            default: ;
        endcase
    end

    // header capture, remaining-word count and write address
    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            cnt_hi     <= '0;
            words_left <= '0;
            imem_addr  <= BASE_ADDR;
        end else begin
            if (xfer && state == LEN_HI) cnt_hi <= byte_data;
            if (xfer && state == LEN_LO) words_left <= CNT_W'(hdr_cnt);
            if (state == WRITE) begin
                imem_addr  <= imem_addr + 32'(WORD_BYTES);
                words_left <= words_left - CNT_W'(1);
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // running XOR of every stream byte ahead of the checksum byte
    always_ff @(posedge clk_fpga) begin
        if (reset)                        csum <= '0;
        else if (xfer && state != CSUM)   csum <= csum ^ byte_data;
    end
`endif

    // sticky status flags; DONE and ERROR are terminal so these never both rise
    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
        end else begin
            done     <= (state == DONE);
            error    <= (state == ERROR);
            cpu_hold <= (state != DONE);
        end
    end

    word_assembler u_asm (
        .clk       (clk_fpga),
        .reset     (reset),
        .clr       (asm_clr),
        .shift_en  (asm_shift),
        .byte_in   (byte_data),
        .word      (imem_wdata),
        .word_full (word_full)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: drives length-prefixed images with random gaps and
// compares the write log against addresses/words derived from the image.
module tb_imem_loader;
    import mips_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 256;

    logic        clk_fpga = 1'b0;
    logic        reset = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready, imem_we, cpu_hold, done, error;
    logic [31:0] imem_addr, imem_wdata;

    int          total = 0;
    int          bad = 0;
    logic [63:0] wq[$];
    logic [31:0] img[$];
    logic [7:0]  xsum;

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .CNT_W(16)) dut (
        .clk_fpga   (clk_fpga),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk_fpga = ~clk_fpga;

    // write log
    always @(negedge clk_fpga) if (imem_we) wq.push_back({imem_addr, imem_wdata});

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        byte_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk_fpga);
        @(negedge clk_fpga);
        reset = 1'b0;
        xsum = 8'h00;
        wq.delete();
    endtask

    // offer one byte (after an optional random gap) until it is taken
    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int gap;
        bit got;
        gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        repeat (gap) begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            @(negedge clk_fpga);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            chk("ready_vs_we", byte_ready, !imem_we);
            got = byte_ready;
            @(negedge clk_fpga);
        end
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        chk("xfer_taken", got, 1'b1);
        xsum = xsum ^ b;
    endtask

    // header value n, then every word in img, MSB first
    task automatic load_image(input int maxgap, input int n);
        logic [31:0] w;
        for (int i = 0; i < HDR_BYTES; i++)
            send_byte(8'(n >> (8 * (HDR_BYTES - 1 - i))), maxgap);
        for (int k = 0; k < img.size(); k++) begin
            w = img[k];
            for (int j = 0; j < WORD_BYTES; j++)
                send_byte(w[31 - 8*j -: 8], maxgap);
            chk("we_latency", imem_we, 1'b1);
        end
    endtask

    task automatic finish_load(input bit good);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(good ? xsum : (xsum ^ 8'h5A), 0);
`else
        if (!good) $display("note: corrupt checksum requested without checksum build");
`endif
    endtask

    task automatic expect_end(input bit exp_done);
        int i = 0;
        while (!(done || error) && i < 10) begin
            @(negedge clk_fpga);
            i++;
        end
        @(negedge clk_fpga);
        chk("done", done, exp_done);
        chk("error", error, !exp_done);
        chk("cpu_hold", cpu_hold, !exp_done);
        chk("ready_at_end", byte_ready, 1'b0);
    endtask

    task automatic check_writes();
        chk("nwrites", wq.size(), img.size());
        for (int k = 0; k < wq.size() && k < img.size(); k++) begin
            chk("waddr", wq[k][63:32], BASE + 32'(4 * k));
            chk("wdata", wq[k][31:0], img[k]);
        end
    endtask

    initial begin
        @(negedge clk_fpga);
        do_reset();
        chk("rst_ready", byte_ready, 1'b1);
        chk("rst_we", imem_we, 1'b0);
        chk("rst_addr", imem_addr, BASE);
        chk("rst_wdata", imem_wdata, 32'h0);
        chk("rst_hold", cpu_hold, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);

        // two-word reference image, no gaps
        img = '{32'h2008_0005, 32'hAC08_0004};
        load_image(0, img.size());
        finish_load(1'b1);
        expect_end(1'b1);
        check_writes();

        // same image with gaps and valid held across write cycles
        do_reset();
        load_image(3, img.size());
        finish_load(1'b1);
        expect_end(1'b1);
        check_writes();

        // random image
        do_reset();
        img.delete();
        for (int k = 0; k < 6; k++) img.push_back($urandom);
        load_image(2, img.size());
        finish_load(1'b1);
        expect_end(1'b1);
        check_writes();

        // empty image
        do_reset();
        img.delete();
        load_image(0, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        finish_load(1'b1);
        expect_end(1'b1);
`else
        chk("n0_done_early", done, 1'b0);
        @(negedge clk_fpga);
        chk("n0_done", done, 1'b1);
        chk("n0_hold", cpu_hold, 1'b0);
        chk("n0_error", error, 1'b0);
`endif
        chk("n0_nwrites", wq.size(), 0);

        // largest legal header is accepted
        do_reset();
        load_image(0, MAXW);
        @(negedge clk_fpga);
        chk("max_error", error, 1'b0);
        chk("max_ready", byte_ready, 1'b1);

        // one past the limit is rejected
        do_reset();
        load_image(0, MAXW + 1);
        expect_end(1'b0);
        chk("over_nwrites", wq.size(), 0);

        // reset in the middle of the second word, then reload a fresh image
        do_reset();
        img = '{$urandom, $urandom};
        for (int i = 0; i < HDR_BYTES; i++) send_byte(8'(2 >> (8 * (HDR_BYTES - 1 - i))), 0);
        for (int j = 0; j < 5; j++) send_byte(8'($urandom), 1);
        do_reset();
        img = '{$urandom};
        load_image(1, 1);
        finish_load(1'b1);
        expect_end(1'b1);
        check_writes();

`ifdef IMEM_LOADER_CHECKSUM_EN
        // bad checksum: words still written, CPU stays held
        do_reset();
        img = '{32'h2008_0005, 32'hAC08_0004};
        load_image(0, img.size());
        finish_load(1'b0);
        expect_end(1'b0);
        check_writes();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
